// File: rtl/datapath_mc.sv
// Purpose : parametrised microcoded datapath with RF, flagged ALU, shift-add multiplier and in/out handshakes.
// Latency : RF/R_in/z_out/flags update one edge after the micro-op; multiply writes RF WIDTH cycles after start.
// Backpres: stall (combinational) asks the sequencer to hold the micro-op; busy marks an active multiply.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   fld_A, fld_B, fld_C   RF read addresses (operands A/B) and write address
//   ldRF, selR_in         RF write enable; write source (1 = R_in, 0 = ALU result)
//   ldR_in, x_in, x_valid load input register from x_in when x_valid is high
//   ldR_out, z_out,       load output register with ALU result; z_valid marks unconsumed
//   z_valid, z_ack        data, z_ack consumes it
//   alu_op                ALU opcode
//   mul_start             start A*B, low half of the product lands in RF[fld_C]
//   cy, neg, zero, ovf    registered status flags
//   stall, busy           hold request and multiplier-active indication
//
// Optional feature macro: ZERO_REG_EN -- when defined, RF[0] reads as zero and
// every write addressed to it (ALU or multiplier) is dropped.
module datapath_mc #(
  parameter int WIDTH = 8,
  parameter int NREGS = 8,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    fld_A,
  input  logic [AW-1:0]    fld_B,
  input  logic [AW-1:0]    fld_C,
  input  logic             ldRF,
  input  logic             selR_in,
  input  logic             ldR_in,
  input  logic             ldR_out,
  input  logic [2:0]       alu_op,
  input  logic             mul_start,
  input  logic [WIDTH-1:0] x_in,
  input  logic             x_valid,
  output logic [WIDTH-1:0] z_out,
  output logic             z_valid,
  input  logic             z_ack,
  output logic             cy,
  output logic             neg,
  output logic             zero,
  output logic             ovf,
  output logic             stall,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
  // Largest positive signed value, 0111..1: INC overflows exactly here.
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_XOR = 3'b010,
    OP_INC = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  // Architectural state
  logic [WIDTH-1:0]   rf_q [NREGS];
  logic [WIDTH-1:0]   rf_d [NREGS];
  logic [WIDTH-1:0]   r_in_q, r_in_d;
  logic [WIDTH-1:0]   z_out_q, z_out_d;
  logic               z_valid_q, z_valid_d;
  logic               cy_q, cy_d;
  logic               neg_q, neg_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;

  // Multiplier state
  logic               busy_q, busy_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      dest_q, dest_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  // Combinational intermediates
  logic [WIDTH-1:0]   opa, opb;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;
  logic [WIDTH:0]     sum_w;
  logic               in_stall, out_stall, busy_stall;
  logic               flag_upd;
  logic               alu_wr_ok, mul_wr_ok;
  logic [WIDTH-1:0]   wr_data;
  logic [2*WIDTH-1:0] mul_add, mul_acc_nxt;
  logic [WIDTH-1:0]   mul_lo;
  logic               mul_last;

  // ---------------------------------------------------------------------------
  // Register file read ports (combinational; a same-cycle write is not visible)
  // ---------------------------------------------------------------------------
  always_comb begin
    opa = rf_q[fld_A];
    opb = rf_q[fld_B];
`ifdef ZERO_REG_EN
    if (fld_A == '0) opa = '0;
    if (fld_B == '0) opb = '0;
`endif
  end

`ifdef ZERO_REG_EN
  assign alu_wr_ok = (fld_C != '0);
  assign mul_wr_ok = (dest_q != '0);
`else
  assign alu_wr_ok = 1'b1;
  assign mul_wr_ok = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sum_w   = '0;
    case (alu_op_e'(alu_op))
      OP_ADD: begin
        sum_w   = {1'b0, opa} + {1'b0, opb};
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (opa[WIDTH-1] == opb[WIDTH-1]) && (alu_res[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_SUB: begin
        // Bit WIDTH of the extended difference is the borrow (A < B unsigned).
        sum_w   = {1'b0, opa} - {1'b0, opb};
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (opa[WIDTH-1] != opb[WIDTH-1]) && (alu_res[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_XOR: alu_res = opa ^ opb;
      OP_INC: begin
        sum_w   = {1'b0, opa} + (WIDTH+1)'(1);
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (opa == SMAX);
      end
      OP_AND: alu_res = opa & opb;
      OP_OR:  alu_res = opa | opb;
      OP_SHL: begin
        alu_res = {opa[WIDTH-2:0], 1'b0};
        alu_c   = opa[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, opa[WIDTH-1:1]};
        alu_c   = opa[0];
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stall: any part of the micro-op that cannot finish holds the whole micro-op.
  // While the multiplier runs it owns the RF write port and the flags.
  // ---------------------------------------------------------------------------
  assign in_stall   = ldR_in && !x_valid;
  assign out_stall  = ldR_out && z_valid_q && !z_ack;
  assign busy_stall = busy_q && (ldRF || ldR_out);
  assign stall      = in_stall || out_stall || busy_stall;

  assign flag_upd = (ldRF && !selR_in) || ldR_out;
  assign wr_data  = selR_in ? r_in_q : alu_res;

  // ---------------------------------------------------------------------------
  // Multiplier datapath: multiplicand shifts left, multiplier shifts right, one
  // partial product per busy cycle. The last step's sum is written straight to
  // the RF so the write lands on the edge where busy drops.
  // ---------------------------------------------------------------------------
  assign mul_add     = mplier_q[0] ? mcand_q : '0;
  assign mul_acc_nxt = acc_q + mul_add;
  assign mul_lo      = mul_acc_nxt[WIDTH-1:0];
  assign mul_last    = busy_q && (cnt_q == LAST_STEP);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    rf_d      = rf_q;
    r_in_d    = r_in_q;
    z_out_d   = z_out_q;
    z_valid_d = z_valid_q;
    cy_d      = cy_q;
    neg_d     = neg_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    dest_d    = dest_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;

    if (!stall) begin
      if (ldRF && alu_wr_ok) rf_d[fld_C] = wr_data;
      if (ldR_in) r_in_d = x_in;

      if (ldR_out) begin
        z_out_d   = alu_res;
        z_valid_d = 1'b1;
      end else if (z_ack) begin
        z_valid_d = 1'b0;
      end

      if (flag_upd) begin
        cy_d   = alu_c;
        ovf_d  = alu_v;
        neg_d  = alu_res[WIDTH-1];
        zero_d = (alu_res == '0);
      end

      if (mul_start && !busy_q) begin
        busy_d   = 1'b1;
        cnt_d    = '0;
        dest_d   = fld_C;
        mcand_d  = {{WIDTH{1'b0}}, opa};
        mplier_d = opb;
        acc_d    = '0;
      end
    end

    // No ALU write or flag update can coincide with this: busy stalls them.
    if (busy_q) begin
      acc_d    = mul_acc_nxt;
      mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
      cnt_d    = cnt_q + CW'(1);
      if (mul_last) begin
        if (mul_wr_ok) rf_d[dest_q] = mul_lo;
        cy_d   = |mul_acc_nxt[2*WIDTH-1:WIDTH];
        zero_d = (mul_lo == '0);
        neg_d  = mul_lo[WIDTH-1];
        ovf_d  = 1'b0;
        busy_d = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      r_in_q    <= '0;
      z_out_q   <= '0;
      z_valid_q <= 1'b0;
      cy_q      <= 1'b0;
      neg_q     <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      dest_q    <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
    end else begin
      rf_q      <= rf_d;
      r_in_q    <= r_in_d;
      z_out_q   <= z_out_d;
      z_valid_q <= z_valid_d;
      cy_q      <= cy_d;
      neg_q     <= neg_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      dest_q    <= dest_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
    end
  end

  assign z_out   = z_out_q;
  assign z_valid = z_valid_q;
  assign cy      = cy_q;
  assign neg     = neg_q;
  assign zero    = zero_q;
  assign ovf     = ovf_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_datapath_mc.sv
// Purpose : randomized + directed bench for datapath_mc with a scoreboard on z_out.
// Latency : one micro-op per step; model advances at each clock edge.
// Backpres: drives z_ack randomly; consumption is observed by a separate monitor.
module tb_datapath_mc;

  localparam int W    = 8;
  localparam int N    = 8;
  localparam int AW   = 3;
  localparam int MASK = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] fld_A, fld_B, fld_C;
  logic          ldRF, selR_in, ldR_in, ldR_out, mul_start, x_valid, z_ack;
  logic [2:0]    alu_op;
  logic [W-1:0]  x_in;
  logic [W-1:0]  z_out;
  logic          z_valid, cy, neg, zero, ovf, stall, busy;

  datapath_mc #(.WIDTH(W), .NREGS(N)) dut (
    .clk(clk), .rst(rst),
    .fld_A(fld_A), .fld_B(fld_B), .fld_C(fld_C),
    .ldRF(ldRF), .selR_in(selR_in), .ldR_in(ldR_in), .ldR_out(ldR_out),
    .alu_op(alu_op), .mul_start(mul_start),
    .x_in(x_in), .x_valid(x_valid),
    .z_out(z_out), .z_valid(z_valid), .z_ack(z_ack),
    .cy(cy), .neg(neg), .zero(zero), .ovf(ovf),
    .stall(stall), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  // Reference model state
  int     m_rf[N];
  int     m_rin, m_z;
  bit     m_zv, m_cy, m_neg, m_zero, m_ovf, m_busy;
  int     m_left, m_dest;
  longint m_prod;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rd(input int a);
`ifdef ZERO_REG_EN
    if (a == 0) return 0;
`endif
    return m_rf[a];
  endfunction

  function automatic void wr(input int a, input int d);
`ifdef ZERO_REG_EN
    if (a == 0) return;
`endif
    m_rf[a] = d & MASK;
  endfunction

  // ALU rules evaluated with plain integer arithmetic.
  function automatic void alu_model(input int op, input int a, input int b,
                                    output int res, output bit c, output bit v);
    int sa, sb, full, smax, smin;
    smax = (1 << (W-1)) - 1;
    smin = -(1 << (W-1));
    sa = (a > smax) ? a - (1 << W) : a;
    sb = (b > smax) ? b - (1 << W) : b;
    res = 0; c = 0; v = 0;
    case (op)
      0: begin full = a + b; res = full & MASK; c = (full > MASK);
               v = (sa + sb > smax) || (sa + sb < smin); end
      1: begin res = (a - b) & MASK; c = (a < b);
               v = (sa - sb > smax) || (sa - sb < smin); end
      2: res = a ^ b;
      3: begin full = a + 1; res = full & MASK; c = (full > MASK); v = (sa + 1 > smax); end
      4: res = a & b;
      5: res = a | b;
      6: begin res = (a * 2) & MASK; c = ((a >> (W-1)) & 1) != 0; end
      default: begin res = a / 2; c = (a % 2) != 0; end
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_rf[i] = 0;
    m_rin = 0; m_z = 0; m_zv = 0;
    m_cy = 0; m_neg = 0; m_zero = 0; m_ovf = 0;
    m_busy = 0; m_left = 0; m_dest = 0; m_prod = 0;
    exp_q.delete();
  endfunction

  task automatic idle();
    ldRF = 0; selR_in = 0; ldR_in = 0; ldR_out = 0; mul_start = 0;
    alu_op = 3'd0; fld_A = '0; fld_B = '0; fld_C = '0;
    x_in = '0; x_valid = 0; z_ack = 0;
  endtask

  // One cycle: compare DUT against model state, then advance the model.
  task automatic step();
    int a, b, res;
    bit c, v, st, was_busy;
    @(negedge clk);
    a = rd(int'(fld_A));
    b = rd(int'(fld_B));
    alu_model(int'(alu_op), a, b, res, c, v);
    st = (ldR_in && !x_valid) || (ldR_out && m_zv && !z_ack) || (m_busy && (ldRF || ldR_out));
    chk("stall", 64'(stall), 64'(st));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("z_valid", 64'(z_valid), 64'(m_zv));
    chk("z_out", 64'(z_out), 64'(m_z));
    chk("flags", 64'({cy, neg, zero, ovf}), 64'({m_cy, m_neg, m_zero, m_ovf}));

    was_busy = m_busy;
    if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        wr(m_dest, int'(m_prod & MASK));
        m_cy   = (m_prod >> W) != 0;
        m_zero = (m_prod & MASK) == 0;
        m_neg  = ((m_prod >> (W-1)) & 1) != 0;
        m_ovf  = 0;
        m_busy = 0;
      end
    end
    if (!st) begin
      if (ldRF) wr(int'(fld_C), selR_in ? m_rin : res);
      if (ldR_in) m_rin = int'(x_in);
      if (ldR_out) begin
        m_z = res; m_zv = 1; exp_q.push_back(res);
      end else if (z_ack) begin
        m_zv = 0;
      end
      if ((ldRF && !selR_in) || ldR_out) begin
        m_cy = c; m_ovf = v; m_neg = res >= (1 << (W-1)); m_zero = (res == 0);
      end
      if (mul_start && !was_busy) begin
        m_busy = 1; m_left = W; m_dest = int'(fld_C);
        m_prod = longint'(a) * longint'(b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a value leaves z_out when it is acked on a non-stalled edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && z_valid && z_ack && !stall) begin
        if (exp_q.size() == 0) chk("sb_underflow", 64'(exp_q.size()), 64'd1);
        else chk("sb_z_out", 64'(z_out), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic do_reset();
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic load_reg(input int r, input int val);
    idle(); ldR_in = 1; x_valid = 1; x_in = W'(val); step();
    idle(); ldRF = 1; selR_in = 1; fld_C = AW'(r); step();
  endtask

  task automatic read_reg(input int r);
    idle(); ldR_out = 1; alu_op = 3'b101; fld_A = AW'(r); fld_B = AW'(r); step();
  endtask

  task automatic ack();
    idle(); z_ack = 1; step();
  endtask

  int stall_cnt;
  int n;
  int edge_vals[4];

  initial begin
    edge_vals[0] = 'h00; edge_vals[1] = 'h7F; edge_vals[2] = 'h80; edge_vals[3] = 'hFF;
    do_reset();
    chk("rst_z_valid", 64'(z_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_flags", 64'({cy, neg, zero, ovf}), 64'd0);
    chk("rst_z_out", 64'(z_out), 64'd0);

    // ADD 0x7F + 0x01
    load_reg(1, 'h7F);
    load_reg(2, 'h01);
    idle(); ldRF = 1; alu_op = 3'b000; fld_A = 1; fld_B = 2; fld_C = 3; step();
    chk("add_flags", 64'({cy, neg, zero, ovf}), 64'(4'b0101));
    read_reg(3);
    chk("add_res", 64'(z_out), 64'h80);
    ack();

    // SUB 1 - 127 and 127 - 127
    idle(); ldR_out = 1; alu_op = 3'b001; fld_A = 2; fld_B = 1; step();
    chk("sub_res", 64'(z_out), 64'h82);
    chk("sub_cy", 64'(cy), 64'd1);
    ack();
    idle(); ldRF = 1; alu_op = 3'b001; fld_A = 1; fld_B = 1; fld_C = 4; step();
    chk("sub_zero", 64'(zero), 64'd1);
    chk("sub_zero_cy", 64'(cy), 64'd0);

    // Input handshake: three starved cycles then data
    stall_cnt = 0;
    idle(); ldR_in = 1; x_valid = 0; x_in = 'hFF;
    for (int i = 0; i < 3; i++) begin
      #1; if (stall) stall_cnt++;
      step();
    end
    x_valid = 1; x_in = 'hA5;
    #1; if (stall) stall_cnt++;
    step();
    chk("in_stall_cycles", 64'(stall_cnt), 64'd3);
    idle(); ldRF = 1; selR_in = 1; fld_C = 5; step();
    read_reg(5);
    chk("r_in_val", 64'(z_out), 64'hA5);
    ack();

    // Output handshake: second load waits for ack
    read_reg(1);
    chk("out1_valid", 64'(z_valid), 64'd1);
    chk("out1_val", 64'(z_out), 64'h7F);
    idle(); ldR_out = 1; alu_op = 3'b010; fld_A = 1; fld_B = 2;
    #1; chk("out2_stall", 64'(stall), 64'd1);
    step(); step();
    chk("out2_hold", 64'(z_out), 64'h7F);
    z_ack = 1;
    #1; chk("out2_release", 64'(stall), 64'd0);
    step();
    chk("out2_val", 64'(z_out), 64'h7E);
    chk("out2_valid", 64'(z_valid), 64'd1);
    ack();
    chk("out_drained", 64'(z_valid), 64'd0);

    // Multiply 0x12 * 0x34 = 0x03A8, with ldRF attempts while busy
    load_reg(6, 'h12);
    load_reg(7, 'h34);
    idle(); mul_start = 1; fld_A = 6; fld_B = 7; fld_C = 3; step();
    idle(); ldRF = 1; selR_in = 1; fld_C = 3;
    n = 0;
    while (busy && n < 20) begin
      n++;
      #1; chk("mul_ldrf_stall", 64'(stall), 64'd1);
      step();
    end
    idle();
    chk("mul_busy_cycles", 64'(n), 64'd8);
    chk("mul_flags", 64'({cy, neg, zero, ovf}), 64'(4'b1100));
    read_reg(3);
    chk("mul_res", 64'(z_out), 64'hA8);
    ack();

    // Register 0 behaviour
    load_reg(0, 'h55);
    read_reg(0);
`ifdef ZERO_REG_EN
    chk("reg0_read", 64'(z_out), 64'h00);
`else
    chk("reg0_read", 64'(z_out), 64'h55);
`endif
    ack();

    // Reset during a multiply aborts it
    idle(); mul_start = 1; fld_A = 6; fld_B = 7; fld_C = 4; step();
    idle(); repeat (3) step();
    do_reset();
    chk("abort_busy", 64'(busy), 64'd0);
    idle(); repeat (10) step();
    read_reg(4);
    chk("abort_no_write", 64'(z_out), 64'h00);
    ack();

    // Randomized micro-ops
    for (int i = 0; i < 4000; i++) begin
      ldRF      = ($urandom_range(0, 3) == 0);
      selR_in   = ($urandom_range(0, 1) == 0);
      ldR_in    = ($urandom_range(0, 3) == 0);
      ldR_out   = ($urandom_range(0, 2) == 0);
      mul_start = ($urandom_range(0, 9) == 0);
      alu_op    = 3'($urandom_range(0, 7));
      fld_A     = AW'($urandom_range(0, N-1));
      fld_B     = AW'($urandom_range(0, N-1));
      fld_C     = AW'($urandom_range(0, N-1));
      x_in      = W'($urandom_range(0, MASK));
      if ($urandom_range(0, 3) == 0) x_in = W'(edge_vals[$urandom_range(0, 3)]);
      x_valid   = ($urandom_range(0, 4) != 0);
      z_ack     = ($urandom_range(0, 1) == 0);
      step();
    end

    // Drain outstanding output and multiply
    idle(); z_ack = 1;
    for (int i = 0; i < 40 && (busy || z_valid); i++) step();
    chk("drain_busy", 64'(busy), 64'd0);
    chk("drain_valid", 64'(z_valid), 64'd0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
